scenario_sequencer: RTL and testbench

Parametrised successor to the bus test-scenario controller. It stores a programmable table of bus transaction steps instead of hard-wired scenarios, and plays them back in order. For each step it drives enable, read-enable, address and data to up to NUM_M master ports, then waits for the bus to go quiet before advancing. It adds a per-step pre-delay, a timeout check, abort and status reporting. It sits between the testbench/top-level stimulus and the master interface modules.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/seq_step_ram.sv | 23 ++
 rtl/scenario_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_scenario_sequencer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and step-word layout helpers for the scenario sequencer.
// Step word, MSB to LSB: {pre_delay[7:0], rd_mask, en_mask, addr, data}.
package seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam int PD_W  = 8;
  localparam int CNT_W = 8;

  localparam int F_DATA = 0;
  localparam int F_ADDR = 1;
  localparam int F_EN   = 2;
  localparam int F_RD   = 3;
  localparam int F_PD   = 4;

  function automatic int field_lsb(input int field, input int num_m, input int dw, input int aw);
    case (field)
      F_DATA:  return 0;
      F_ADDR:  return dw;
      F_EN:    return dw + aw;
      F_RD:    return dw + aw + num_m;
      default: return dw + aw + 2 * num_m;
    endcase
  endfunction

  // A pre-delay of 0 still costs one DELAY cycle, so 0 and 1 load the same count.
  function automatic logic [CNT_W-1:0] delay_load(input logic [PD_W-1:0] pd);
    return (pd == '0) ? '0 : pd - 8'd1;
  endfunction

endpackage

// File: rtl/seq_step_ram.sv
// Step table: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module seq_step_ram #(
  parameter int DEPTH = 16,
  parameter int SW    = 34
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [SW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [SW-1:0]            rdata
);

  logic [SW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/scenario_sequencer.sv
// Plays back a programmable table of bus steps to NUM_M master ports,
// with per-step pre-delay, bus-quiet wait with timeout, abort and status.
//
// state   | meaning
// IDLE    | waiting for start, table writable
// DELAY   | counting the step's pre-delay, all master outputs 0
// ISSUE   | enables asserted for EN_CYCLES cycles
// WAIT    | enables low, waiting for all m_request low or timeout
// DONE    | playback finished, table writable, waits for start/abort
module scenario_sequencer
  import seq_pkg::*;
#(
  parameter int NUM_M     = 2,
  parameter int DW        = 8,
  parameter int AW        = 14,
  parameter int DEPTH     = 16,
  parameter int EN_CYCLES = 3,
  parameter int TIMEOUT   = 255,
  parameter int SW        = DW + AW + 2 * NUM_M + 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [SW-1:0]            cfg_wdata,
  input  logic [$clog2(DEPTH):0]   num_steps,
  input  logic [NUM_M-1:0]         m_request,
  output logic [NUM_M-1:0]         m_enable,
  output logic [NUM_M-1:0]         m_read_en,
  output logic [NUM_M*DW-1:0]      data_in,
  output logic [NUM_M*AW-1:0]      addr_in,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout_err,
  output logic [$clog2(DEPTH)-1:0] step_idx
);

  localparam int IW = $clog2(DEPTH);
  localparam int NW = IW + 1;

  localparam int DATA_LSB = field_lsb(F_DATA, NUM_M, DW, AW);
  localparam int ADDR_LSB = field_lsb(F_ADDR, NUM_M, DW, AW);
  localparam int EN_LSB   = field_lsb(F_EN,   NUM_M, DW, AW);
  localparam int RD_LSB   = field_lsb(F_RD,   NUM_M, DW, AW);
  localparam int PD_LSB   = field_lsb(F_PD,   NUM_M, DW, AW);

  localparam logic [CNT_W-1:0] EN_LOAD  = CNT_W'(EN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TMO_LOAD = CNT_W'(TIMEOUT - 1);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [IW-1:0]     step_idx_next;
  logic [NW-1:0]     steps_q, steps_req;
  logic              tmo_set;
  logic              idle_like, start_ok, wait_exit, is_last, wr_en;

  logic [SW-1:0]     rd_word;
  logic [DW-1:0]     f_data;
  logic [AW-1:0]     f_addr;
  logic [NUM_M-1:0]  f_en, f_rd;
  logic [PD_W-1:0]   f_pd;

  logic [NUM_M-1:0]    issue_en, issue_rd;
  logic [NUM_M*AW-1:0] issue_addr;
  logic [NUM_M*DW-1:0] issue_data;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign start_ok  = idle_like && start && !abort;
  assign wr_en     = idle_like && cfg_we;
  assign wait_exit = (state == S_WAIT) && ((m_request == '0) || (cnt == '0));
  assign is_last   = (NW'(step_idx) + NW'(1)) == steps_q;
  assign steps_req = (num_steps > NW'(DEPTH)) ? NW'(DEPTH) : num_steps;

  // Read port follows the next index so the pre-delay of the upcoming step
  // can be loaded on the same edge that moves into DELAY.
  seq_step_ram #(.DEPTH(DEPTH), .SW(SW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (cfg_addr),
    .wdata (cfg_wdata),
    .raddr (step_idx_next),
    .rdata (rd_word)
  );

  assign f_data = rd_word[DATA_LSB +: DW];
  assign f_addr = rd_word[ADDR_LSB +: AW];
  assign f_en   = rd_word[EN_LSB +: NUM_M];
  assign f_rd   = rd_word[RD_LSB +: NUM_M];
  assign f_pd   = rd_word[PD_LSB +: PD_W];

  always_comb begin
    step_idx_next = step_idx;
    if (abort)                     step_idx_next = '0;
    else if (start_ok)             step_idx_next = '0;
    else if (wait_exit && !is_last) step_idx_next = step_idx + IW'(1);
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    tmo_set    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_ok) begin
          if (steps_req == '0) begin
            state_next = S_DONE;
          end else begin
            state_next = S_DELAY;
            cnt_next   = delay_load(f_pd);
          end
        end
      end
      S_DELAY: begin
        if (cnt == '0) begin
          state_next = S_ISSUE;
          cnt_next   = EN_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_ISSUE: begin
        if (cnt == '0) begin
          state_next = S_WAIT;
          cnt_next   = TMO_LOAD;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      S_WAIT: begin
        if (wait_exit) begin
          tmo_set = (m_request != '0);
          if (is_last) begin
            state_next = S_DONE;
            cnt_next   = '0;
          end else begin
            state_next = S_DELAY;
            cnt_next   = delay_load(f_pd);
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
    if (abort) begin
      state_next = S_IDLE;
      cnt_next   = '0;
      tmo_set    = 1'b0;
    end
  end

  // Unmasked masters stay 0; read steps carry no data.
  always_comb begin
    issue_en   = '0;
    issue_rd   = '0;
    issue_addr = '0;
    issue_data = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (f_en[i]) begin
        issue_en[i]             = 1'b1;
        issue_rd[i]             = f_rd[i];
        issue_addr[i*AW +: AW]  = f_addr + AW'(i);
        if (!f_rd[i]) issue_data[i*DW +: DW] = f_data + DW'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      step_idx    <= '0;
      steps_q     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      step_idx <= step_idx_next;
      if (start_ok) steps_q <= steps_req;
      if (start_ok)     timeout_err <= 1'b0;
      else if (tmo_set) timeout_err <= 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_enable  <= '0;
      m_read_en <= '0;
      addr_in   <= '0;
      data_in   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      busy <= (state_next == S_DELAY) || (state_next == S_ISSUE) || (state_next == S_WAIT);
      done <= (state_next == S_DONE);
      case (state_next)
        S_ISSUE: begin
          m_enable  <= issue_en;
          m_read_en <= issue_rd;
          addr_in   <= issue_addr;
          data_in   <= issue_data;
        end
        S_WAIT: begin
          m_enable <= '0;
        end
        default: begin
          m_enable  <= '0;
          m_read_en <= '0;
          addr_in   <= '0;
          data_in   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scenario_sequencer.sv
// Self-checking bench: per-cycle output traces compared against a step-level
// model built from the table contents, pre-delays and request hold times.
module tb_scenario_sequencer;
  localparam int NUM_M = 2, DW = 8, AW = 14, DEPTH = 16, EN_CYCLES = 3, TIMEOUT = 255;
  localparam int SW = DW + AW + 2 * NUM_M + 8;

  logic clk = 1'b0, reset = 1'b0;
  logic start = 1'b0, abort = 1'b0, cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [SW-1:0] cfg_wdata = '0;
  logic [4:0] num_steps = '0;
  logic [NUM_M-1:0] m_request = '0;
  logic [NUM_M-1:0] m_enable, m_read_en;
  logic [NUM_M*DW-1:0] data_in;
  logic [NUM_M*AW-1:0] addr_in;
  logic busy, done, timeout_err;
  logic [3:0] step_idx;

  scenario_sequencer #(.NUM_M(NUM_M), .DW(DW), .AW(AW), .DEPTH(DEPTH),
                       .EN_CYCLES(EN_CYCLES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .num_steps(num_steps),
    .m_request(m_request), .m_enable(m_enable), .m_read_en(m_read_en),
    .data_in(data_in), .addr_in(addr_in), .busy(busy), .done(done),
    .timeout_err(timeout_err), .step_idx(step_idx)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]      en;
    logic [1:0]      rd;
    logic [2*AW-1:0] addr;
    logic [2*DW-1:0] data;
    logic            busy;
    logic            done;
    logic [3:0]      idx;
    logic            err;
  } obs_t;

  obs_t          exp_q[$], act_q[$];
  logic [1:0]    req_q[$];
  logic [SW-1:0] tbl[DEPTH];
  int            hold_a[DEPTH];
  logic [1:0]    rmask_a[DEPTH];
  int compared = 0, mismatched = 0;

  function automatic logic [SW-1:0] mk_word(int pd, logic [1:0] rd, logic [1:0] en, int addr, int data);
    return {8'(pd), rd, en, 14'(addr), 8'(data)};
  endfunction

  function automatic obs_t sample();
    return {m_enable, m_read_en, addr_in, data_in, busy, done, step_idx, timeout_err};
  endfunction

  // Expected trace: one entry per cycle after the start edge.
  task automatic build_expected(input int nst);
    int n, pd, d, h, wl, addr, data;
    logic err;
    logic [1:0] en, rd;
    logic [SW-1:0] w;
    obs_t e;
    n = (nst > DEPTH) ? DEPTH : nst;
    err = 1'b0;
    exp_q.delete();
    req_q.delete();
    for (int s = 0; s < n; s++) begin
      w = tbl[s];
      data = int'(w[7:0]); addr = int'(w[21:8]);
      en = w[23:22]; rd = w[25:24]; pd = int'(w[33:26]);
      d = (pd == 0) ? 1 : pd;
      e = '0; e.busy = 1'b1; e.idx = 4'(s); e.err = err;
      for (int k = 0; k < d; k++) begin exp_q.push_back(e); req_q.push_back(2'($urandom)); end
      for (int i = 0; i < NUM_M; i++) begin
        if (en[i]) begin
          e.en[i] = 1'b1;
          e.rd[i] = rd[i];
          e.addr[i*AW +: AW] = 14'((addr + i) % 16384);
          if (!rd[i]) e.data[i*DW +: DW] = 8'((data + i) % 256);
        end
      end
      for (int k = 0; k < EN_CYCLES; k++) begin exp_q.push_back(e); req_q.push_back(2'($urandom)); end
      e.en = '0;
      h = (rmask_a[s] == 2'b00) ? 0 : hold_a[s];
      wl = (h >= TIMEOUT) ? TIMEOUT : h + 1;
      for (int k = 0; k < wl; k++) begin
        exp_q.push_back(e);
        req_q.push_back((k < h) ? rmask_a[s] : 2'b00);
      end
      if (h >= TIMEOUT) err = 1'b1;
    end
    e = '0; e.done = 1'b1; e.idx = (n == 0) ? 4'd0 : 4'(n - 1); e.err = err;
    for (int k = 0; k < 2; k++) begin exp_q.push_back(e); req_q.push_back(2'($urandom)); end
  endtask

  task automatic write_step(input int a, input logic [SW-1:0] w);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_wdata = w;
    @(negedge clk);
    cfg_we = 1'b0;
    tbl[a] = w;
  endtask

  task automatic clear_holds();
    for (int i = 0; i < DEPTH; i++) begin hold_a[i] = 0; rmask_a[i] = 2'b00; end
  endtask

  // Runs one playback; stops early (without advancing) at stop_at if >= 0.
  task automatic play(input int nst, input bit inject, input int stop_at);
    build_expected(nst);
    act_q.delete();
    num_steps = 5'(nst);
    @(negedge clk);
    start = 1'b1; m_request = 2'($urandom);
    @(negedge clk);
    start = 1'b0;
    for (int t = 0; t < exp_q.size(); t++) begin
      act_q.push_back(sample());
      m_request = req_q[t];
      if (t == stop_at) return;
      if (inject && t == 1) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = ~tbl[0];
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      @(negedge clk);
    end
    m_request = '0;
  endtask

  task automatic test_reset();
    obs_t o;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    o = sample();
    compared++;
    if (o !== obs_t'('0)) begin mismatched++; $display("FAIL reset_state got %h want 0", o); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b01, 1001, 212));
    hold_a[0] = 4; rmask_a[0] = 2'b01;
    play(1, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL single_write t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
  endtask

  task automatic test_broadcast();
    obs_t o;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b11, 5097, 102));
    hold_a[0] = 2; rmask_a[0] = 2'b11;
    play(1, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL broadcast t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    o = act_q[1];
    compared++;
    if (o.addr !== {14'd5098, 14'd5097} || o.data !== {8'd103, 8'd102} || o.en !== 2'b11) begin
      mismatched++; $display("FAIL broadcast_issue got en=%b addr=%h data=%h", o.en, o.addr, o.data);
    end
  endtask

  task automatic test_two_steps();
    int first;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b01, 100, 20));
    write_step(1, mk_word(8, 2'b10, 2'b10, 200, 30));
    hold_a[0] = 2; rmask_a[0] = 2'b01;
    hold_a[1] = 1; rmask_a[1] = 2'b10;
    play(2, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL two_steps t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    first = -1;
    foreach (act_q[t]) if (first < 0 && act_q[t].en == 2'b10) first = t;
    compared++;
    if (first < 0 || act_q[first].rd !== 2'b10 || act_q[first].idx !== 4'd1) begin
      mismatched++; $display("FAIL two_steps_read first_issue=%0d want read_en=10 idx=1", first);
    end
  endtask

  task automatic test_wrap();
    obs_t o;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b11, 16383, 255));
    play(1, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL wrap t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    o = act_q[1];
    compared++;
    if (o.addr !== {14'd0, 14'd16383} || o.data !== {8'd0, 8'd255}) begin
      mismatched++; $display("FAIL wrap_issue got addr=%h data=%h want addr=00003fff data=00ff", o.addr, o.data);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b11, 50, 60));
    hold_a[0] = 1000; rmask_a[0] = 2'b10;
    play(1, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL timeout t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    o = act_q[act_q.size() - 1];
    compared++;
    if (o.err !== 1'b1 || o.done !== 1'b1 || act_q.size() != 1 + EN_CYCLES + TIMEOUT + 2) begin
      mismatched++; $display("FAIL timeout_end got err=%b done=%b len=%0d want err=1 done=1 len=%0d", o.err, o.done, act_q.size(), 1 + EN_CYCLES + TIMEOUT + 2);
    end
  endtask

  task automatic test_abort();
    obs_t o, z;
    int stop;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b01, 10, 11));
    write_step(1, mk_word(2, 2'b00, 2'b11, 300, 7));
    hold_a[0] = 1000; rmask_a[0] = 2'b01;
    stop = 1 + EN_CYCLES + TIMEOUT + 2 + 1;   // second ISSUE cycle of step 1
    play(2, 1'b0, stop);
    for (int t = 0; t <= stop; t++) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL abort_prefix t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    z = '0; z.err = 1'b1;
    for (int k = 0; k < 2; k++) begin
      o = sample();
      compared++;
      if (o !== z) begin mismatched++; $display("FAIL abort_idle k=%0d got %h want %h", k, o, z); end
      @(negedge clk);
    end
    m_request = '0;
  endtask

  task automatic test_cfg_busy();
    clear_holds();
    write_step(0, mk_word(3, 2'b01, 2'b11, 4000, 50));
    write_step(1, mk_word(1, 2'b00, 2'b00, 0, 0));
    hold_a[0] = 1; rmask_a[0] = 2'b11;
    hold_a[1] = 2; rmask_a[1] = 2'b11;
    play(2, 1'b1, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL cfg_busy t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    compared++;
    if (act_q[0].err !== 1'b0) begin mismatched++; $display("FAIL err_clear got %b want 0", act_q[0].err); end
    play(2, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL cfg_replay t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
  endtask

  task automatic test_random();
    int nst;
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < DEPTH; s++) begin
        write_step(s, mk_word($urandom_range(0, 6), 2'($urandom), 2'($urandom),
                              int'($urandom_range(0, 16383)), int'($urandom_range(0, 255))));
        hold_a[s] = $urandom_range(0, 5);
        rmask_a[s] = 2'($urandom);
      end
      nst = (r == 0) ? 0 : (r == 1) ? 18 : $urandom_range(1, DEPTH);
      play(nst, 1'b0, -1);
      foreach (exp_q[t]) begin
        compared++;
        if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL random r=%0d n=%0d t=%0d got %h want %h", r, nst, t, act_q[t], exp_q[t]); end
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    clear_holds();
    write_step(0, mk_word(0, 2'b00, 2'b01, 77, 9));
    hold_a[0] = 50; rmask_a[0] = 2'b01;
    play(1, 1'b0, 6);
    for (int t = 0; t <= 6; t++) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL rst_prefix t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
    #2 reset = 1'b0;
    #1 o = sample();
    compared++;
    if (o !== obs_t'('0)) begin mismatched++; $display("FAIL rst_mid_wait got %h want 0", o); end
    m_request = '0;
    @(negedge clk);
    reset = 1'b1;
    hold_a[0] = 0;
    play(1, 1'b0, -1);
    foreach (exp_q[t]) begin
      compared++;
      if (act_q[t] !== exp_q[t]) begin mismatched++; $display("FAIL rst_table_kept t=%0d got %h want %h", t, act_q[t], exp_q[t]); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_holds();
    test_reset();
    test_single_write();
    test_broadcast();
    test_two_steps();
    test_wrap();
    test_timeout();
    test_abort();
    test_cfg_busy();
    test_random();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
